// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller driving shared-port valid/tag/data SRAMs.
// A miss fetches a 32-byte line, refills all three arrays in one write and answers from the captured line.
module icache_ctrl #(
    parameter  int S_INDEX = 4,
    localparam int TAG_W   = 32 - 5 - S_INDEX
) (
    input  logic               clk0,
    input  logic               rst0,
    input  logic               ufp_req,
    input  logic [31:0]        ufp_addr,
    output logic [31:0]        ufp_rdata,
    output logic               ufp_resp,
    output logic               dfp_read,
    output logic [31:0]        dfp_addr,
    input  logic [255:0]       dfp_rdata,
    input  logic               dfp_resp,
    output logic               arr_csb,
    output logic               arr_web,
    output logic [S_INDEX-1:0] arr_addr,
    output logic               valid_din,
    input  logic               valid_dout,
    output logic [TAG_W-1:0]   tag_din,
    input  logic [TAG_W-1:0]   tag_dout,
    output logic [255:0]       data_din,
    input  logic [255:0]       data_dout
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS,
        FILL
    } state_e;

    state_e       state_q, state_d;
    logic [31:2]  addr_q, addr_d;
    logic [255:0] line_q, line_d;

    logic [TAG_W-1:0]   addr_tag;
    logic [S_INDEX-1:0] addr_idx;
    logic [2:0]         addr_word;
    logic               hit;
    logic [255:0]       src_line;
    logic               unused_byte_offset;

    assign addr_tag  = addr_q[31:5+S_INDEX];
    assign addr_idx  = addr_q[4+S_INDEX:5];
    assign addr_word = addr_q[4:2];
    assign hit       = valid_dout && (tag_dout == addr_tag);

    // Fetches are word-granular; the byte offset never affects the result.
    assign unused_byte_offset = ^ufp_addr[1:0];

    assign valid_din = 1'b1;
    assign tag_din   = addr_tag;
    assign data_din  = line_q;
    assign ufp_rdata = src_line[{addr_word, 5'b0} +: 32];

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q <= IDLE;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        line_d   = line_q;
        ufp_resp = 1'b0;
        dfp_read = 1'b0;
        dfp_addr = '0;
        arr_csb  = 1'b1;
        arr_web  = 1'b1;
        arr_addr = '0;
        src_line = data_dout;
        case (state_q)
            IDLE: begin
                if (ufp_req) begin
                    addr_d   = ufp_addr[31:2];
                    arr_csb  = 1'b0;
                    arr_addr = ufp_addr[4+S_INDEX:5];
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    ufp_resp = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d  = MISS;
                end
            end
            MISS: begin
                dfp_read = 1'b1;
                dfp_addr = {addr_q[31:5], 5'b0};
                if (dfp_resp) begin
                    line_d  = dfp_rdata;
                    state_d = FILL;
                end
            end
            FILL: begin
                // Answer from the captured line; the array write only lands at the next edge.
                arr_csb  = 1'b0;
                arr_web  = 1'b0;
                arr_addr = addr_idx;
                ufp_resp = 1'b1;
                src_line = line_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
